// File: rtl/display_pkg.sv
// Shared display definitions: coordinate and colour widths plus the sprite FSM state type.
package display_pkg;

    localparam int CORDW = 16;
    localparam int COLRW = 4;

    typedef enum logic [2:0] {
        IDLE,
        REG_POS,
        WAIT_POS,
        DRAW,
        DONE
    } spr_state_t;

endpackage

// File: rtl/sprite_render.sv
// Single-line sprite renderer feeding an external one-cycle ROM; pix/drawing trail sx by 3 cycles.
// Optional horizontal mirroring via the flip_h input when SPR_FLIP_EN is defined.
module sprite_render #(
    parameter int CORDW  = display_pkg::CORDW,
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int COLRW  = display_pkg::COLRW,
    parameter int TRANSP = 0,
    parameter int ADDRW  = $clog2(SPR_W * SPR_H)
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
`ifdef SPR_FLIP_EN
    input  logic                    flip_h,
`endif
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [COLRW-1:0]        rom_data,
    output logic [COLRW-1:0]        pix,
    output logic                    drawing
);

    import display_pkg::*;

    localparam logic signed [CORDW-1:0] ONE      = CORDW'(1);
    localparam logic signed [CORDW-1:0] W_C      = CORDW'(SPR_W);
    localparam logic signed [CORDW-1:0] LAST_COL = CORDW'(SPR_W - 1);
    localparam logic signed [CORDW-1:0] LAST_ROW = CORDW'(SPR_H - 1);
    localparam logic [COLRW-1:0]        TRANSP_C = COLRW'(TRANSP);

    spr_state_t state, state_next;

    logic signed [CORDW-1:0] sprx_r, spry_r, sy_r;
    logic signed [CORDW-1:0] row, col, col_addr;
    logic                    in_range, issue;
    logic                    draw_q1, draw_q2;
    logic [COLRW-1:0]        data_q;

    assign in_range = (sy_r >= spry_r) && (sy_r <= spry_r + LAST_ROW);
    // The line-pulse cycle never issues a column, so a row cut off at line end cannot leak into blanking.
    assign issue    = (state == DRAW) && !line;

`ifdef SPR_FLIP_EN
    logic flip_r;
    assign col_addr = flip_r ? (LAST_COL - col) : col;
`else
    assign col_addr = col;
`endif

    assign rom_addr = ADDRW'(row * W_C + col_addr);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) state <= IDLE;
        else            state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = IDLE;
            REG_POS:  state_next = in_range ? WAIT_POS : DONE;
            // Arm one pixel early so DRAW column 0 coincides with sx == sprx.
            WAIT_POS: if (sx == sprx_r - ONE) state_next = DRAW;
            DRAW:     if (col == LAST_COL) state_next = DONE;
            DONE:     state_next = DONE;
            default:  state_next = IDLE;
        endcase
        if (line) state_next = REG_POS;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sprx_r  <= '0;
            spry_r  <= '0;
            sy_r    <= '0;
            row     <= '0;
            col     <= '0;
            draw_q1 <= 1'b0;
            draw_q2 <= 1'b0;
            data_q  <= TRANSP_C;
            pix     <= TRANSP_C;
            drawing <= 1'b0;
`ifdef SPR_FLIP_EN
            flip_r  <= 1'b0;
`endif
        end else begin
            if (line) begin
                sprx_r <= sprx;
                spry_r <= spry;
                sy_r   <= sy;
`ifdef SPR_FLIP_EN
                flip_r <= flip_h;
`endif
            end
            if (state == REG_POS) row <= sy_r - spry_r;
            col <= (state == DRAW) ? col + ONE : '0;

            // Address -> ROM -> data register -> output register: three cycles from sx.
            draw_q1 <= issue;
            draw_q2 <= draw_q1;
            data_q  <= rom_data;
            drawing <= draw_q2 && (data_q != TRANSP_C);
            pix     <= (draw_q2 && (data_q != TRANSP_C)) ? data_q : TRANSP_C;
        end
    end

endmodule

// File: tb/tb_sprite_render.sv
// Randomised scoreboard bench for sprite_render with a pixel-level reference model and a sync ROM.
// Define SPR_FLIP_EN for both bench and RTL to exercise mirrored addressing.
module tb_sprite_render;

    localparam int CW      = 16;
    localparam int SW      = 16;
    localparam int SH      = 16;
    localparam int CLW     = 4;
    localparam int TR      = 0;
    localparam int AW      = 8;
    localparam int H_START = -40;
    localparam int H_END   = 639;

    logic                 clk_pix   = 1'b0;
    logic                 rst_pix_n = 1'b0;
    logic                 line      = 1'b0;
    logic signed [CW-1:0] sx   = '0;
    logic signed [CW-1:0] sy   = '0;
    logic signed [CW-1:0] sprx = '0;
    logic signed [CW-1:0] spry = '0;
    logic [AW-1:0]        rom_addr;
    logic [CLW-1:0]       rom_data;
    logic [CLW-1:0]       pix;
    logic                 drawing;
`ifdef SPR_FLIP_EN
    logic                 flip_h = 1'b0;
`endif

    logic [CLW-1:0] rom [SW*SH];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t pix_q[$];
    ev_t addr_q[$];

    sprite_render #(
        .CORDW(CW), .SPR_W(SW), .SPR_H(SH), .COLRW(CLW), .TRANSP(TR), .ADDRW(AW)
    ) dut (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .line     (line),
        .sx       (sx),
        .sy       (sy),
        .sprx     (sprx),
        .spry     (spry),
`ifdef SPR_FLIP_EN
        .flip_h   (flip_h),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix      (pix),
        .drawing  (drawing)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) begin
        rom_data <= rom[rom_addr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an address or a drawn pixel.
    always begin
        ev_t ev;
        @(negedge clk_pix);
        if (rst_pix_n) begin
            if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
                ev = addr_q.pop_front();
                check("rom_addr", int'(rom_addr) == ev.val, int'(rom_addr), ev.val);
            end
            if (drawing) begin
                if (pix_q.size() == 0) begin
                    check("unexpected_draw", drawing == 1'b0, int'(pix), TR);
                end else begin
                    ev = pix_q.pop_front();
                    check("draw_time", ev.cyc == cyc, cyc, ev.cyc);
                    check("pix", int'(pix) == ev.val, int'(pix), ev.val);
                end
            end else begin
                check("idle_transp", int'(pix) == TR, int'(pix), TR);
                if (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
                    ev = pix_q.pop_front();
                    check("missing_draw", drawing == 1'b1, cyc, ev.cyc);
                end
            end
        end
    end

    // One full scan line; the model emits a pixel for every sx covered by the sprite on an in-range row.
    // rst_col >= 0 pulses reset when sx reaches that column of the sprite.
    task automatic run_line(input int px, input int py, input int ly, input bit fl, input int rst_col);
        int  row;
        bit  hit;
        bit  active;
        row    = ly - py;
        hit    = (row >= 0) && (row < SH);
        active = 1'b1;
        for (int x = H_START; x <= H_END; x++) begin
            @(posedge clk_pix);
            #1;
            line = (x == H_START);
            sx   = CW'(x);
            sy   = CW'(ly);
            if (line) begin
                sprx = CW'(px);
                spry = CW'(py);
`ifdef SPR_FLIP_EN
                flip_h = fl;
`endif
            end else begin
                sprx = CW'($urandom);
                spry = CW'($urandom);
`ifdef SPR_FLIP_EN
                flip_h = 1'($urandom);
`endif
            end
            if (rst_col >= 0 && x == px + rst_col) begin
                rst_pix_n = 1'b0;
                pix_q.delete();
                addr_q.delete();
                active = 1'b0;
                #1;
                check("rst_drawing", drawing == 1'b0, int'(drawing), 0);
                check("rst_pix", int'(pix) == TR, int'(pix), TR);
            end else if (!rst_pix_n && rst_col >= 0 && x == px + rst_col + 3) begin
                rst_pix_n = 1'b1;
            end
            if (active && hit && !line && x >= px && x < px + SW) begin
                int c;
                int a;
                c = x - px;
                a = row * SW + (fl ? (SW - 1 - c) : c);
                addr_q.push_back('{cyc, a});
                if (int'(rom[a]) != TR) pix_q.push_back('{cyc + 3, int'(rom[a])});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < SW * SH; i++)
            rom[i] = ($urandom_range(0, 9) < 3) ? CLW'(TR) : CLW'($urandom_range(1, 15));

        repeat (3) @(posedge clk_pix);
        @(negedge clk_pix);
        check("reset_pix", int'(pix) == TR, int'(pix), TR);
        check("reset_drawing", drawing == 1'b0, int'(drawing), 0);
        check("reset_addr", int'(rom_addr) == 0, int'(rom_addr), 0);
        @(posedge clk_pix);
        #1;
        rst_pix_n = 1'b1;

        run_line(100, 50, 50, 1'b0, -1);
        run_line(100, 50, 49, 1'b0, -1);
        run_line(100, 50, 66, 1'b0, -1);
        run_line(100, 50, 65, 1'b0, -1);
        run_line(-8, 50, 51, 1'b0, -1);
        run_line(630, 50, 52, 1'b0, -1);
        run_line(200, 50, 53, 1'b0, -1);
        run_line(100, 50, 55, 1'b0, 5);
        run_line(100, 50, 56, 1'b0, -1);
`ifdef SPR_FLIP_EN
        run_line(100, 50, 52, 1'b1, -1);
`endif
        for (int n = 0; n < 10; n++) begin
            int ly;
            int py;
            int px;
            bit fl;
            ly = $urandom_range(0, 479);
            py = ly - $urandom_range(0, 20) + 2;
            px = $urandom_range(0, 700) - 36;
            fl = 1'b0;
`ifdef SPR_FLIP_EN
            fl = 1'($urandom);
`endif
            run_line(px, py, ly, fl, -1);
        end

        repeat (6) @(posedge clk_pix);
        @(negedge clk_pix);
        check("pix_queue_empty", pix_q.size() == 0, pix_q.size(), 0);
        check("addr_queue_empty", addr_q.size() == 0, addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
